mem_access_stage: RTL and testbench

// - MIPS MEM stage: sits between the EX/MEM pipeline register and the MEM/WB register.
// - Performs the data-memory load/store for the instruction in MEM using a word-addressed data RAM.
// - The RAM has programmable wait states. The stage raises a stall to freeze upstream while busy.
// - Drives readData/ALUResult/writeRegister/WB into MEM/WB, inserting bubbles while stalled.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mem_access_stage_dmem_array.sv | 26 ++
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and MEM-stage FSM state type for the MIPS pipeline slice.
package mips_pkg;

   localparam int WB_W   = 2;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_access_stage_dmem_array.sv
// Word-addressed data RAM: synchronous write, combinational (asynchronous) read.
module dmem_array
   import mips_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Store port: contents are never cleared, only overwritten
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory access with programmable wait states,
// upstream stall generation, bubble insertion and a saturating stall counter.
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int          DEPTH   = 256,
   parameter int          ADDR_W  = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] writeData,
   input  logic [WB_W-1:0]   WB,
   input  logic [REG_W-1:0]  writeRegister,
   output logic [DATA_W-1:0] readData_output,
   output logic [DATA_W-1:0] ALUResult_output,
   output logic [REG_W-1:0]  writeRegister_output,
   output logic [WB_W-1:0]   WB_output,
   output logic              stall,
   output logic [31:0]       stall_count
);

   localparam bit              ZERO_LAT   = (LATENCY == 0);
   localparam logic [CNT_W-1:0] LAT_RELOAD = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

   mem_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic              req;
   logic              busy;
   logic              done;
   logic              mem_we;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] rdata;

   assign req = MemRead | MemWrite;
   assign idx = ALUResult[ADDR_W+1:2];

   // Stall must be known in the same cycle the request arrives, so it is
   // decoded from the registered state rather than registered itself.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      if (!reset) begin
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  if (ZERO_LAT) begin
                     done = 1'b1;
                  end else begin
                     busy = 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt != '0) begin
                  busy = 1'b1;
               end else begin
                  done = 1'b1;
               end
            end
            default: begin
               busy = 1'b0;
               done = 1'b0;
            end
         endcase
      end
   end

   // Store commits only at the closing edge of a completing access
   assign mem_we = done & MemWrite;

   dmem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx),
      .wdata (writeData),
      .rdata (rdata)
   );

   // Output mux: bubble while stalled or in reset, load data only on completion
   always_comb begin
      stall                = busy;
      WB_output            = (reset || busy) ? '0 : WB;
      readData_output      = (done && MemRead) ? rdata : '0;
      ALUResult_output     = ALUResult;
      writeRegister_output = writeRegister;
   end

   // Access FSM and wait-state counter; reset abandons any pending access
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req && !ZERO_LAT) begin
                  state <= ST_WAIT;
                  cnt   <= LAT_RELOAD;
               end
            end
            ST_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Saturating count of stall cycles since reset
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (busy && (stall_count != '1)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: LATENCY=2 and LATENCY=0 instances.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] alu, wdat;
   logic [1:0]  wb;
   logic [4:0]  wreg;
   logic        act;

   logic [31:0] rdo  [2];
   logic [31:0] aluo [2];
   logic [4:0]  rego [2];
   logic [1:0]  wbo  [2];
   logic        stl  [2];
   logic [31:0] scnt [2];

   always #5 clk = ~clk;

   mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut_l2 (
      .clk(clk), .reset(reset),
      .MemRead(rd && (act == 1'b0)), .MemWrite(wr && (act == 1'b0)),
      .ALUResult(alu), .writeData(wdat), .WB(wb), .writeRegister(wreg),
      .readData_output(rdo[0]), .ALUResult_output(aluo[0]),
      .writeRegister_output(rego[0]), .WB_output(wbo[0]),
      .stall(stl[0]), .stall_count(scnt[0])
   );

   mem_access_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(0)) dut_l0 (
      .clk(clk), .reset(reset),
      .MemRead(rd && (act == 1'b1)), .MemWrite(wr && (act == 1'b1)),
      .ALUResult(alu), .writeData(wdat), .WB(wb), .writeRegister(wreg),
      .readData_output(rdo[1]), .ALUResult_output(aluo[1]),
      .writeRegister_output(rego[1]), .WB_output(wbo[1]),
      .stall(stl[1]), .stall_count(scnt[1])
   );

   wire        stall_m = stl[act];
   wire [31:0] rdo_m   = rdo[act];
   wire [31:0] aluo_m  = aluo[act];
   wire [4:0]  rego_m  = rego[act];
   wire [1:0]  wbo_m   = wbo[act];
   wire [31:0] scnt_m  = scnt[act];

   typedef struct {
      logic [31:0] rdat;
      logic [31:0] alu;
      logic [4:0]  wreg;
      logic [1:0]  wb;
      int unsigned stalls;
      logic [31:0] scnt;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [2][256];
   int unsigned tot;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned run   = 0;
   exp_t        me;

   function automatic int unsigned lat_of(input logic a);
      return a ? 0 : 2;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endfunction

   // Reference model: applies the instruction at architectural level
   task automatic issue(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] b, input logic [4:0] rg);
      exp_t        e;
      int unsigned ix;
      bit          ok;
      @(posedge clk); #1;
      rd = r; wr = w; alu = a; wdat = d; wb = b; wreg = rg;
      ix       = (a / 4) % 256;
      e.rdat   = r ? mem_m[act][ix] : 32'h0;
      if (w) mem_m[act][ix] = d;
      e.stalls = (r || w) ? lat_of(act) : 0;
      tot      = tot + e.stalls;
      e.alu = a; e.wreg = rg; e.wb = b; e.scnt = tot;
      q.push_back(e);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!stall_m) begin
            ok = 1'b1;
            break;
         end
      end
      chk("access_complete", {31'h0, ok}, 32'h1);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      rd = 1'b1; wr = $urandom_range(0, 1); alu = $urandom; wdat = $urandom;
      wb = 2'b11; wreg = 5'd7;
      q.delete();
      tot = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; rd = 1'b0; wr = 1'b0;
   endtask

   // Start a store, let it stall once, then reset it away
   task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b1; alu = a; wdat = d; wb = 2'b01; wreg = 5'd3;
      e.rdat = '0; e.alu = a; e.wreg = 5'd3; e.wb = 2'b01; e.stalls = 2; e.scnt = '0;
      q.push_back(e);
      @(negedge clk);
      chk("abort_stalled", {31'h0, stall_m}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1; rd = 1'b0; wr = 1'b0;
      q.delete();
      tot = 0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Monitor: a non-stalled cycle with outstanding work presents a result
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_stall", {31'h0, stall_m}, 32'h0);
         chk("rst_wb", {30'h0, wbo_m}, 32'h0);
         chk("rst_rdata", rdo_m, 32'h0);
         run = 0;
      end else if (stall_m) begin
         chk("stall_outstanding", q.size(), (q.size() == 0) ? 32'h1 : q.size());
         chk("bubble_wb", {30'h0, wbo_m}, 32'h0);
         run++;
      end else if (q.size() != 0) begin
         me = q.pop_front();
         chk("rdata", rdo_m, me.rdat);
         chk("alu_pass", aluo_m, me.alu);
         chk("wreg_pass", {27'h0, rego_m}, {27'h0, me.wreg});
         chk("wb_out", {30'h0, wbo_m}, {30'h0, me.wb});
         chk("stall_cycles", run, me.stalls);
         chk("stall_count", scnt_m, me.scnt);
         run = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rd = 1'b0; wr = 1'b0; alu = '0; wdat = '0; wb = '0; wreg = '0;
      act = 1'b0; tot = 0;

      // LATENCY=2 instance
      do_reset();
      issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b01, 5'd4);
      issue(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 5'd9);
      issue(1'b0, 1'b0, 32'h1234, 32'h0, 2'b10, 5'd5);
      for (int i = 0; i < 256; i++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 32'h3F_FFFF) & 32'h3F_FFFF, 10'h0};
         a[9:2] = i[7:0];
         a[1:0] = 2'($urandom_range(0, 3));
         issue(1'b0, 1'b1, a, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      end
      issue(1'b0, 1'b1, 32'h0000_0400, 32'hA5A5A5A5, 2'b00, 5'd0);
      issue(1'b1, 1'b0, 32'h0000_0003, 32'h0, 2'b01, 5'd1);
      issue(1'b0, 1'b1, 32'h30, 32'h7, 2'b00, 5'd2);
      issue(1'b1, 1'b1, 32'h30, 32'h9, 2'b01, 5'd2);
      issue(1'b1, 1'b0, 32'h30, 32'h0, 2'b01, 5'd2);
      for (int i = 0; i < 200; i++) begin
         int unsigned k;
         k = $urandom_range(0, 3);
         issue(k[0], k[1], $urandom, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      end
      issue(1'b0, 1'b1, 32'h20, 32'h0, 2'b00, 5'd6);
      abort_store(32'h20, 32'h11111111);
      issue(1'b0, 1'b0, 32'h55, 32'h0, 2'b10, 5'd8);
      issue(1'b1, 1'b0, 32'h20, 32'h0, 2'b01, 5'd6);
      idle();

      // LATENCY=0 instance
      act = 1'b1;
      do_reset();
      issue(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 2'b01, 5'd10);
      issue(1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 5'd11);
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, 1'b1, i * 4, $urandom, 2'b00, 5'd0);
      end
      for (int i = 0; i < 100; i++) begin
         int unsigned k;
         logic [31:0] a;
         k = $urandom_range(0, 3);
         a = $urandom;
         a[9:2] = 8'($urandom_range(0, 16));
         issue(k[0], k[1], a, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      end
      idle();
      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
